// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude arithmetic definitions for the signed ALU datapath.
// Contents: default operand width, sign-magnitude word struct, and helpers
// converting sign-magnitude <-> two's complement at the default width.
package sm_arith_pkg;

    localparam int SM_W = 32;

    typedef struct packed {
        logic            sign;  // 1 = negative
        logic [SM_W-2:0] mag;
    } sm_word_t;

    // Result of a back-conversion: the word plus a saturation flag.
    typedef struct packed {
        sm_word_t word;
        logic     ovf;
    } sm_sat_t;

    // Sign-magnitude to SM_W+2-bit two's complement. Both zero encodings map
    // to 0 because negating a zero magnitude yields zero.
    function automatic logic [SM_W+1:0] sm_to_tc(input sm_word_t x);
        logic [SM_W+1:0] m;
        m = {3'b000, x.mag};
        return x.sign ? ((SM_W+2)'(0) - m) : m;
    endfunction

    // SM_W+2-bit two's complement to sign-magnitude. Magnitudes beyond the
    // representable range saturate to all-ones and raise ovf. A zero input
    // always produces +0, since only strictly negative values set the sign.
    function automatic sm_sat_t tc_to_sm(input logic [SM_W+1:0] r);
        sm_sat_t         res;
        logic            neg;
        logic [SM_W+1:0] abs_r;
        neg   = r[SM_W+1];
        abs_r = neg ? ((SM_W+2)'(0) - r) : r;
        res.word.sign = neg;
        res.ovf       = |abs_r[SM_W+1:SM_W-1];
        res.word.mag  = res.ovf ? {(SM_W-1){1'b1}} : abs_r[SM_W-2:0];
        return res;
    endfunction

endpackage

// File: rtl/sm_to_tc_conv.sv
// Combinational sign-magnitude to W+2-bit two's complement converter.
// Ports: sm (W-bit sign-magnitude in), tc (W+2-bit two's complement out).
// Both +0 and -0 produce an all-zero result.
module sm_to_tc_conv #(
    parameter int W = 32
) (
    input  logic [W-1:0] sm,
    output logic [W+1:0] tc
);

    logic [W+1:0] mag_ext;

    always_comb begin
        mag_ext = {3'b000, sm[W-2:0]};
        tc      = sm[W-1] ? ((W+2)'(0) - mag_ext) : mag_ext;
    end

endmodule

// File: rtl/signed_2s_comp_subtractor.sv
// Registered sign-magnitude subtractor: diff = num1 - num2, 1-cycle latency.
// Ports: clk, rst (sync, active-high), in_valid/num1/num2 in;
// out_valid/diff/ovf out. No backpressure; diff/ovf hold when in_valid=0.
module signed_2s_comp_subtractor
    import sm_arith_pkg::*;
#(
    parameter int W = SM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] num2,
    output logic         out_valid,
    output logic [W-1:0] diff,
    output logic         ovf
);

    logic [W+1:0] a_tc;
    logic [W+1:0] b_tc;
    logic [W+1:0] r_tc;
    logic [W+1:0] r_abs;
    logic         r_neg;
    logic         r_sat;
    logic [W-2:0] r_mag;

    logic         out_valid_d, out_valid_q;
    logic [W-1:0] diff_d, diff_q;
    logic         ovf_d, ovf_q;

    sm_to_tc_conv #(.W(W)) u_conv_a (
        .sm (num1),
        .tc (a_tc)
    );

    sm_to_tc_conv #(.W(W)) u_conv_b (
        .sm (num2),
        .tc (b_tc)
    );

    // Operands span +/-(2^(W-1)-1), so the difference fits comfortably in
    // W+2 bits and the subtraction itself cannot wrap.
    always_comb begin
        r_tc  = a_tc - b_tc;
        r_neg = r_tc[W+1];
        r_abs = r_neg ? ((W+2)'(0) - r_tc) : r_tc;
        // Any set bit at or above W-1 means the magnitude exceeds 2^(W-1)-1.
        r_sat = |r_abs[W+1:W-1];
        r_mag = r_sat ? {(W-1){1'b1}} : r_abs[W-2:0];
    end

    // r_neg is only set for strictly negative results, so zero is always +0.
    always_comb begin
        out_valid_d = in_valid;
        diff_d      = diff_q;
        ovf_d       = ovf_q;
        if (in_valid) begin
            diff_d = {r_neg, r_mag};
            ovf_d  = r_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_2s_comp_subtractor.sv
module tb_signed_2s_comp_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        out_valid;
    logic [31:0] diff;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    signed_2s_comp_subtractor #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .diff      (diff),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] exp_diff;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one beat at the falling edge; sample #1 after the capturing edge.
    task automatic drive_beat(input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = v;
        num1     = a;
        num2     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"pos_minus_larger_pos", 32'h00000005, 32'h00000007, 32'h80000002, 1'b0};
        vecs[1]  = '{"neg_minus_neg",        32'h80000003, 32'h80000005, 32'h00000002, 1'b0};
        vecs[2]  = '{"pos_minus_neg",        32'h00000002, 32'h80000002, 32'h00000004, 1'b0};
        vecs[3]  = '{"neg_minus_pos_a",      32'h80000001, 32'h00000003, 32'h80000004, 1'b0};
        vecs[4]  = '{"neg_minus_pos_b",      32'h80000003, 32'h00000002, 32'h80000005, 1'b0};
        vecs[5]  = '{"sat_positive",         32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 1'b1};
        vecs[6]  = '{"sat_negative",         32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{"negzero_minus_zero",   32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[8]  = '{"equal_operands",       32'h00000009, 32'h00000009, 32'h00000000, 1'b0};
        vecs[9]  = '{"zero_minus_negzero",   32'h00000000, 32'h80000000, 32'h00000000, 1'b0};
        vecs[10] = '{"max_minus_zero",       32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 1'b0};
        vecs[11] = '{"exact_max_no_ovf",     32'h7FFFFFFE, 32'h80000001, 32'h7FFFFFFF, 1'b0};
        vecs[12] = '{"exact_neg_max",        32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{"just_over_neg_max",    32'h80000001, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[14] = '{"minus_negzero",        32'h00000003, 32'h80000000, 32'h00000003, 1'b0};
        vecs[15] = '{"neg_minus_neg_to_neg", 32'h80000010, 32'h80000004, 32'h8000000C, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        num1     = '0;
        num2     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_diff", diff, 32'h0);
        check("reset_ovf", {31'b0, ovf}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors, one beat each.
        for (int i = 0; i < 16; i++) begin
            drive_beat(1'b1, vecs[i].n1, vecs[i].n2);
            check({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'h1);
            check({vecs[i].name, "_diff"}, diff, vecs[i].exp_diff);
            check({vecs[i].name, "_ovf"}, {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
        end

        // Idle beat: outputs hold the last result, out_valid drops.
        drive_beat(1'b0, 32'h00000005, 32'h00000007);
        check("idle_valid", {31'b0, out_valid}, 32'h0);
        check("idle_hold_diff", diff, 32'h8000000C);
        check("idle_hold_ovf", {31'b0, ovf}, 32'h0);

        // A saturating result, then reset while in_valid is still high.
        drive_beat(1'b1, 32'h7FFFFFFF, 32'h80000001);
        check("pre_rst_ovf", {31'b0, ovf}, 32'h1);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        num1     = 32'h00000005;
        num2     = 32'h00000001;
        @(posedge clk);
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_diff", diff, 32'h0);
        check("midrst_ovf", {31'b0, ovf}, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Three back-to-back beats produce three consecutive results in order.
        drive_beat(1'b1, 32'h00000001, 32'h00000002);
        check("stream0_valid", {31'b0, out_valid}, 32'h1);
        check("stream0_diff", diff, 32'h80000001);
        drive_beat(1'b1, 32'h00000064, 32'h80000064);
        check("stream1_valid", {31'b0, out_valid}, 32'h1);
        check("stream1_diff", diff, 32'h000000C8);
        drive_beat(1'b1, 32'h80000000, 32'h00000007);
        check("stream2_valid", {31'b0, out_valid}, 32'h1);
        check("stream2_diff", diff, 32'h80000007);
        drive_beat(1'b0, 32'h0, 32'h0);
        check("stream_end_valid", {31'b0, out_valid}, 32'h0);
        check("stream_end_hold", diff, 32'h80000007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
